// File: rtl/pp_buf_ctrl.sv
// Ping-pong controller for two external 1-cycle-read dual-port RAM banks.
// Writer fills one bank while the reader drains the other through a 2-deep skid FIFO.
module pp_buf_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDRW      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [1:0]            ram_ena,
  output logic [1:0]            ram_wea,
  output logic [ADDRW-1:0]      ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dia,
  output logic [1:0]            ram_enb,
  output logic [ADDRW-1:0]      ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob0,
  input  logic [DATA_WIDTH-1:0] ram_dob1,
  output logic [1:0]            bank_full
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  logic             wr_bank_q, wr_bank_d;
  logic [ADDRW-1:0] wr_addr_q, wr_addr_d;
  logic             rd_bank_q, rd_bank_d;
  logic [ADDRW-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]       full_q, full_d;
  logic             infl_q, infl_d;
  logic             infl_bank_q, infl_bank_d;
  logic             infl_last_q, infl_last_d;
  ent_t             fifo_q [2];
  ent_t             fifo_d [2];
  logic             wp_q, wp_d;
  logic             rp_q, rp_d;
  logic [1:0]       cnt_q, cnt_d;

  logic             wr_fire;
  logic             wr_last;
  logic             rd_issue;
  logic             rd_last;
  logic             push;
  logic             pop;
  logic [1:0]       occ;
  ent_t             push_ent;

  always_comb begin
    wr_fire  = s_valid && !full_q[wr_bank_q];
    wr_last  = wr_addr_q == LAST_ADDR;
    pop      = (cnt_q != 2'd0) && m_ready;
    push     = infl_q;
    // slots committed once this cycle's pop leaves and the in-flight read lands
    occ      = cnt_q - 2'(pop) + 2'(infl_q);
    rd_issue = full_q[rd_bank_q] && (occ < 2'd2);
    rd_last  = rd_addr_q == LAST_ADDR;
    push_ent.last = infl_last_q;
    push_ent.data = infl_bank_q ? ram_dob1 : ram_dob0;
  end

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    full_d      = full_q;
    infl_d      = rd_issue;
    infl_bank_d = infl_bank_q;
    infl_last_d = infl_last_q;
    if (wr_fire) begin
      wr_addr_d = wr_addr_q + 1'b1;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (rd_issue) begin
      rd_addr_d   = rd_addr_q + 1'b1;
      infl_bank_d = rd_bank_q;
      infl_last_d = rd_last;
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_comb begin
    fifo_d = fifo_q;
    wp_d   = wp_q ^ push;
    rp_d   = rp_q ^ pop;
    cnt_d  = cnt_q;
    if (push) fifo_d[wp_q] = push_ent;
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + 2'd1;
      pop && !push: cnt_d = cnt_q - 2'd1;
      default:      cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      full_q      <= 2'b00;
      infl_q      <= 1'b0;
      infl_bank_q <= 1'b0;
      infl_last_q <= 1'b0;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      cnt_q       <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      full_q      <= full_d;
      infl_q      <= infl_d;
      infl_bank_q <= infl_bank_d;
      infl_last_q <= infl_last_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      fifo_q      <= fifo_d;
    end
  end

  assign s_ready   = !full_q[wr_bank_q];
  assign ram_ena   = wr_fire ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
  assign ram_wea   = ram_ena;
  assign ram_addra = wr_addr_q;
  assign ram_dia   = wr_fire ? s_data : '0;
  assign ram_enb   = rd_issue ? (rd_bank_q ? 2'b10 : 2'b01) : 2'b00;
  assign ram_addrb = rd_addr_q;
  assign m_valid   = cnt_q != 2'd0;
  assign m_data    = fifo_q[rp_q].data;
  assign m_last    = fifo_q[rp_q].last;
  assign bank_full = full_q;

endmodule

// File: tb/tb_pp_buf_ctrl.sv
// Bench for pp_buf_ctrl: behavioural RAM banks, queue scoreboard and
// per-scenario tasks with randomized data and handshakes.
module tb_pp_buf_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic [1:0]    ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dia;
  logic [DW-1:0] ram_dob0 = '0;
  logic [DW-1:0] ram_dob1 = '0;
  logic [1:0]    bank_full;

  pp_buf_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dia(ram_dia), .ram_enb(ram_enb), .ram_addrb(ram_addrb),
    .ram_dob0(ram_dob0), .ram_dob1(ram_dob1), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (ram_ena[0] && ram_wea[0]) mem0[ram_addra] <= ram_dia;
    if (ram_ena[1] && ram_wea[1]) mem1[ram_addra] <= ram_dia;
    ram_dob0 <= ram_enb[0] ? mem0[ram_addrb] : '0;
    ram_dob1 <= ram_enb[1] ? mem1[ram_addrb] : '0;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_idx = 0;
  int rd_idx = 0;
  int enb_cnt = 0;
  int iss15_cyc = -1;
  logic [DW-1:0] sb [$];
  int out_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: word k of the stream lives in bank (k/DEPTH)%2 at k%DEPTH
  always @(negedge clk) begin
    if (rst_n) begin
      logic [1:0] exp_en;
      logic [DW-1:0] exp_d;
      logic exp_last;
      checks++;
      if (ram_enb == 2'b11) begin
        errors++;
        $display("FAIL enb_onehot: ram_enb=%b, required one-hot or zero", ram_enb);
      end
      checks++;
      if ((ram_ena & bank_full) != 2'b00) begin
        errors++;
        $display("FAIL write_to_full: ram_ena=%b bank_full=%b", ram_ena, bank_full);
      end
      if (ram_enb != 2'b00) begin
        enb_cnt++;
        if (ram_enb == 2'b01 && ram_addrb == AW'(DEPTH - 1)) iss15_cyc = cyc;
      end
      checks++;
      if (s_valid && s_ready) begin
        exp_en = ((wr_idx / DEPTH) % 2 == 1) ? 2'b10 : 2'b01;
        if (ram_ena !== exp_en || ram_wea !== exp_en ||
            ram_addra !== AW'(wr_idx % DEPTH) || ram_dia !== s_data) begin
          errors++;
          $display("FAIL write_port word %0d: ena=%b wea=%b addr=%0d dia=%h, required ena=wea=%b addr=%0d dia=%h",
                   wr_idx, ram_ena, ram_wea, ram_addra, ram_dia, exp_en, wr_idx % DEPTH, s_data);
        end
        sb.push_back(s_data);
        wr_idx++;
      end else if (ram_ena !== 2'b00 || ram_wea !== 2'b00) begin
        errors++;
        $display("FAIL idle_write: ena=%b wea=%b, required 00", ram_ena, ram_wea);
      end
      if (m_valid && m_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_output: data=%h with empty scoreboard", m_data);
        end else begin
          exp_d = sb.pop_front();
          exp_last = (rd_idx % DEPTH) == DEPTH - 1;
          if (m_data !== exp_d || m_last !== exp_last) begin
            errors++;
            $display("FAIL out_word %0d: data=%h last=%b, required data=%h last=%b",
                     rd_idx, m_data, m_last, exp_d, exp_last);
          end
        end
        rd_idx++;
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    out_cyc.delete();
    wr_idx = 0;
    rd_idx = 0;
    enb_cnt = 0;
    iss15_cyc = -1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_out(input int n, input int bound);
    for (int k = 0; k < bound && rd_idx < n; k++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    s_data = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, m_data} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_out: m_valid=%b m_last=%b m_data=%h, required 0 0 0", m_valid, m_last, m_data);
    end
    apply_reset();
    s_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({ram_ena, ram_wea, ram_enb} !== 6'b0 || ram_addra !== '0 ||
        ram_addrb !== '0 || ram_dia !== '0) begin
      errors++;
      $display("FAIL reset_ram: ena=%b wea=%b enb=%b addra=%0d addrb=%0d dia=%h, required all 0",
               ram_ena, ram_wea, ram_enb, ram_addra, ram_addrb, ram_dia);
    end
    checks++;
    if (bank_full !== 2'b00 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: bank_full=%b s_ready=%b m_valid=%b, required 00 1 0",
               bank_full, s_ready, m_valid);
    end
  endtask

  task automatic test_single_bank();
    int n;
    int miss;
    apply_reset();
    m_ready = 1'b1;
    miss = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data = DW'(i);
      @(negedge clk);
      if (!s_ready) miss++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 3 || miss != 0) begin
      errors++;
      $display("FAIL single_latency: m_valid after %0d cycles (refused %0d), required 3 (0)", n, miss);
    end
    wait_out(DEPTH, 50);
    checks++;
    if (rd_idx != DEPTH || sb.size() != 0) begin
      errors++;
      $display("FAIL single_count: %0d out, %0d left, required %0d out, 0 left", rd_idx, sb.size(), DEPTH);
    end
  endtask

  task automatic test_streaming();
    int drops;
    apply_reset();
    m_ready = 1'b1;
    drops = 0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data = $urandom;
      @(negedge clk);
      if (!s_ready) drops++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_out(4 * DEPTH, 100);
    checks++;
    if (drops != 0 || rd_idx != 4 * DEPTH) begin
      errors++;
      $display("FAIL stream_flow: s_ready low %0d cycles, %0d out, required 0 and %0d", drops, rd_idx, 4 * DEPTH);
    end
    checks++;
    if (out_cyc.size() != 4 * DEPTH || out_cyc[out_cyc.size() - 1] - out_cyc[0] != 4 * DEPTH - 1) begin
      errors++;
      $display("FAIL stream_rate: %0d words, span not %0d cycles", out_cyc.size(), 4 * DEPTH - 1);
    end
  endtask

  task automatic test_stall();
    int k;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data = $urandom;
    end
    @(negedge clk); #1;
    checks++;
    if (wr_idx != 2 * DEPTH || bank_full !== 2'b11 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_fill: accepted=%0d bank_full=%b s_ready=%b, required %0d 11 0",
               wr_idx, bank_full, s_ready, 2 * DEPTH);
    end
    checks++;
    if (enb_cnt != 2 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_reads: enb pulses=%0d m_valid=%b, required 2 1", enb_cnt, m_valid);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    k = 0;
    while (!s_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (iss15_cyc < 0 || cyc - iss15_cyc != 1) begin
      errors++;
      $display("FAIL stall_ready: s_ready at cycle %0d, addr-15 issue at %0d, required 1 cycle apart", cyc, iss15_cyc);
    end
    wait_out(2 * DEPTH, 200);
    checks++;
    if (rd_idx != 2 * DEPTH || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_drain: %0d out, %0d left, required %0d 0", rd_idx, sb.size(), 2 * DEPTH);
    end
  endtask

  task automatic test_random();
    int total;
    total = ((1000 + DEPTH - 1) / DEPTH) * DEPTH;
    apply_reset();
    for (int k = 0; k < 20000 && wr_idx < total; k++) begin
      @(posedge clk); #1;
      s_valid = (wr_idx < total) && ($urandom_range(0, 1) == 1);
      s_data = $urandom;
      m_ready = $urandom_range(0, 1) == 1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_out(total, 200);
    checks++;
    if (wr_idx != total || rd_idx != total || sb.size() != 0) begin
      errors++;
      $display("FAIL random_sb: in=%0d out=%0d left=%0d, required %0d %0d 0",
               wr_idx, rd_idx, sb.size(), total, total);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 100 && wr_idx < 20; k++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data = $urandom;
      @(negedge clk); #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || bank_full !== 2'b00 || s_ready !== 1'b1 ||
        ram_ena !== 2'b00 || ram_enb !== 2'b00 || ram_addra !== '0 || ram_addrb !== '0) begin
      errors++;
      $display("FAIL midreset_async: m_valid=%b m_data=%h full=%b s_ready=%b ena=%b enb=%b addra=%0d addrb=%0d",
               m_valid, m_data, bank_full, s_ready, ram_ena, ram_enb, ram_addra, ram_addrb);
    end
    sb.delete();
    out_cyc.delete();
    wr_idx = 0;
    rd_idx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data = 32'hA000_0000 + DW'(i);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_out(DEPTH, 60);
    repeat (10) @(negedge clk);
    checks++;
    if (wr_idx != DEPTH || rd_idx != DEPTH || sb.size() != 0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after: in=%0d out=%0d left=%0d m_valid=%b, required %0d %0d 0 0",
               wr_idx, rd_idx, sb.size(), m_valid, DEPTH, DEPTH);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_bank();
    test_streaming();
    test_stall();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pp_buf_ctrl.md
# pp_buf_ctrl

Ping-pong buffer controller that sequences two external simple dual-port RAM banks (`dp_ram` instances, 1-cycle registered read, read data forced to 0 when read-enable is low). The writer fills one bank from a valid/ready input stream while the reader drains the other bank to a valid/ready output stream. Banks swap roles automatically when a fill or drain completes. It sits between the sample source and the downstream processing stage inside the ping-pong buffer IP.

## Interface
- `DATA_WIDTH`, 32, word width
- `DEPTH`, 16, words per bank; must equal 2^`ADDRW`
- `ADDRW`, 4, RAM address width

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `s_valid`  in  1  input word valid
- `s_data`  in  DATA_WIDTH  input word
- `s_ready`  out  1  controller accepts input word
- `m_valid`  out  1  output word valid
- `m_data`  out  DATA_WIDTH  output word
- `m_last`  out  1  marks word DEPTH-1 of a bank
- `m_ready`  in  1  downstream accepts output word
- `ram_ena`  out  2  per-bank write-port enable
- `ram_wea`  out  2  per-bank write enable
- `ram_addra`  out  ADDRW  write address, shared by both banks
- `ram_dia`  out  DATA_WIDTH  write data, shared by both banks
- `ram_enb`  out  2  per-bank read enable
- `ram_addrb`  out  ADDRW  read address, shared by both banks
- `ram_dob0`, `ram_dob1`  in  DATA_WIDTH  bank read data
- `bank_full`  out  2  per-bank full flag, bit i = bank i

## Operation
- **State:**
  - `wr_bank` and `wr_addr` for the write side.
  - `rd_bank` and `rd_addr` for the read side.
  - `full[1:0]`.
  - A registered read-in-flight flag plus the bank that read came from.
  - A 2-entry output FIFO of {data, last}.
- **Write side:**
  - `s_ready = !full[wr_bank]` (combinational).
  - On `s_valid && s_ready`: drive `ram_ena[wr_bank]=ram_wea[wr_bank]=1`, `ram_addra=wr_addr`, `ram_dia=s_data`, then increment `wr_addr`.
  - On the write with `wr_addr==DEPTH-1`: set `full[wr_bank]`, toggle `wr_bank`, `wr_addr` wraps to 0.
- **Read side:**
  - Issue a read when `full[rd_bank]` is set and (FIFO occupancy after this cycle's pop) + in-flight < 2.
  - On issue: `ram_enb[rd_bank]=1`, `ram_addrb=rd_addr`, then increment `rd_addr`. Only one `ram_enb` bit is ever high.
- **Read completion:**
  - The cycle after an issue, the controller pushes the selected bank's dob (selected by the registered bank) into the FIFO.
  - `last` is set if the read address was DEPTH-1.
- **Release:**
  - On the issue of `rd_addr==DEPTH-1`: clear `full[rd_bank]` at that edge, toggle `rd_bank`, `rd_addr` wraps to 0.
  - The RAM has already sampled the location, so the writer may overwrite it from the next cycle on.
- **Output:**
  - `m_valid` = FIFO non-empty; `m_data`/`m_last` = FIFO head.
  - Pop on `m_valid && m_ready`.
  - Push and pop may occur in the same cycle.
- **Simultaneous events:**
  - Set of `full[x]` by the writer and clear of `full[y]` by the reader in the same cycle are independent.
  - x==y cannot occur, because the writer never targets a full bank.
- Data order is preserved exactly; no word is dropped or duplicated.

## Timing
- **Reset (async assert, sync release):**
  - `wr_bank=rd_bank=0`, addresses 0, `full=00`, FIFO empty, no read in flight.
  - Outputs: `m_valid=0`, `m_last=0`, `m_data=0`, `ram_ena`/`ram_wea`/`ram_enb=00`, addresses 0, `ram_dia=0`, `bank_full=00`.
  - `s_ready=1` (no bank is full).
- **Reset mid-operation:** all contents are discarded; the next accepted word goes to bank 0, address 0.
- **Latency:**
  - Final write of a bank in cycle W → first read issue in W+1 → dob valid in W+2 → `m_valid` in W+3.
- **Throughput:**
  - 1 word/cycle on each side with `m_ready` held high.
  - With continuous streaming, `s_ready` never drops.
- **Backpressure with `m_ready=0`:**
  - Reads stop with FIFO + in-flight = 2.
  - `s_ready` falls once both banks are full, i.e. after 2·DEPTH accepted words with none drained beyond the FIFO.
- `bank_full` mirrors `full` registered, with no extra delay.

## Test plan
- **Single bank:** DEPTH=16, write values 0..15 with `m_ready=1` → `m_data` 0..15 in order, `m_last` only on 15, first `m_valid` exactly 3 cycles after the write of 15.
- **Streaming:** 64 words, `s_valid` and `m_ready` held high → `s_ready` stays 1 throughout; output equals input at 1 word/cycle; `m_last` on words 15, 31, 47, 63; banks alternate 0,1,0,1.
- **Stall:** `m_ready=0`, offer 40 words → exactly 32 accepted; `bank_full=11`; `s_ready=0`; exactly 2 `ram_enb` pulses issued. Then raise `m_ready` → 32 words out in order; `s_ready` returns the cycle after bank 0's addr-15 read issue.
- **Random ready:** random 50% `s_valid`/`m_ready`, 1000 words → scoreboard match with no drops or duplicates. Checkers: `ram_enb` one-hot-or-zero, and no write to a bank whose `full` is set.
- **Mid-run reset:** pull `rst_n` low after 20 accepted words → all outputs take reset values asynchronously. After release, write 16 new words → the new words appear with `ram_addra` starting at 0 on bank 0; no stale data is output.
